mac_kbd_sched: RTL



---
 rtl/mac_kbd_pkg.sv | 25 ++
 rtl/kbd_event_fifo.sv | 51 +++++
 rtl/mac_kbd_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mac_kbd_pkg.sv
// mac_kbd_pkg: command codes, response/prefix bytes, FSM states and key-byte expansion helpers
package mac_kbd_pkg;
    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;
    localparam logic [7:0] RSP_NULL    = 8'h7B;
    localparam logic [7:0] RSP_MODEL   = 8'h0B;
    localparam logic [7:0] RSP_ACK     = 8'h7D;
    localparam logic [7:0] PFX_KEYPAD  = 8'h79;
    localparam logic [7:0] PFX_SHIFT   = 8'h71;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // ext bits count the prefix bytes, so the last stage index is ext[0]+ext[1]
    function automatic logic ev_last(input logic [9:0] ev, input logic [1:0] stage);
        return stage == ({1'b0, ev[8]} + {1'b0, ev[9]});
    endfunction

    // ext=11 sends SHIFT then KEYPAD; ext=01 only KEYPAD; ext=10 only SHIFT
    function automatic logic [7:0] ev_byte(input logic [9:0] ev, input logic [1:0] stage);
        return ev_last(ev, stage) ? ev[7:0] :
               ((ev[9:8] == 2'b11 && stage == 2'd1) || ev[9:8] == 2'b01) ? PFX_KEYPAD : PFX_SHIFT;
    endfunction
endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: 10-bit key-event FIFO with synchronous push/pop/flush.
// Ports: clk, reset_n (async low); push_i/pop_i/flush_i, data_i; head_o, level_o, full_o, empty_o.
module kbd_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [9:0]               data_i,
    output logic [9:0]               head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [9:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q;
    logic          do_push, do_pop;

    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign empty_o = level_q == '0;
    assign do_pop  = pop_i && !empty_o;
    // a pop frees the slot the same cycle, so a full FIFO still accepts
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/mac_kbd_sched.sv
// mac_kbd_sched: buffers HID key events and answers Mac Plus host commands one byte at a time.
// Ports: clk, reset_n (async low); kbd_strobe/kbd_data key input; cmd_valid/cmd_byte/cmd_ready host
// command; rsp_valid/rsp_byte/rsp_ready response; fifo_level events stored; overflow drop pulse.
module mac_kbd_sched
    import mac_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int INQ_TIMEOUT = 8_000_000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          kbd_strobe,
    input  logic [9:0]                    kbd_data,
    input  logic                          cmd_valid,
    input  logic [7:0]                    cmd_byte,
    output logic                          cmd_ready,
    output logic                          rsp_valid,
    output logic [7:0]                    rsp_byte,
    input  logic                          rsp_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int TW = $clog2(INQ_TIMEOUT);

    state_t        state_q, state_d;
    logic [7:0]    rsp_q, rsp_d;
    logic          from_fifo_q, from_fifo_d;
    logic [1:0]    stage_q, stage_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          strobe_q, overflow_q;
    logic [9:0]    head;
    logic          full, empty, push, pop, flush;

    assign push      = strobe_q != kbd_strobe;
    assign pop       = state_q == S_RESP && rsp_ready && from_fifo_q && ev_last(head, stage_q);
    assign flush     = state_q == S_IDLE && cmd_valid && cmd_byte == CMD_MODEL;
    assign cmd_ready = state_q == S_IDLE;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_byte  = rsp_q;
    assign overflow  = overflow_q;

    kbd_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (kbd_data),
        .head_o  (head),
        .level_o (fifo_level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d     = state_q;
        rsp_d       = rsp_q;
        from_fifo_d = 1'b0;
        stage_d     = stage_q;
        timer_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_byte)
                        CMD_INQUIRY: begin
                            state_d     = empty ? S_WAIT : S_RESP;
                            rsp_d       = empty ? rsp_q : ev_byte(head, stage_q);
                            from_fifo_d = !empty;
                        end
                        CMD_INSTANT: begin
                            state_d     = S_RESP;
                            rsp_d       = empty ? RSP_NULL : ev_byte(head, stage_q);
                            from_fifo_d = !empty;
                        end
                        CMD_MODEL: begin
                            state_d = S_RESP;
                            rsp_d   = RSP_MODEL;
                            stage_d = 2'd0;
                        end
                        CMD_TEST: begin
                            state_d = S_RESP;
                            rsp_d   = RSP_ACK;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_WAIT: begin
                timer_d = timer_q == '1 ? timer_q : timer_q + 1'b1;
                if (!empty) begin
                    state_d     = S_RESP;
                    rsp_d       = ev_byte(head, stage_q);
                    from_fifo_d = 1'b1;
                end else if (timer_q == TW'(INQ_TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    rsp_d   = RSP_NULL;
                end
            end
            S_RESP: begin
                from_fifo_d = from_fifo_q;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    if (from_fifo_q) stage_d = ev_last(head, stage_q) ? 2'd0 : stage_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rsp_q       <= 8'h00;
            from_fifo_q <= 1'b0;
            stage_q     <= 2'd0;
            timer_q     <= '0;
            strobe_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_q       <= rsp_d;
            from_fifo_q <= from_fifo_d;
            stage_q     <= stage_d;
            timer_q     <= timer_d;
            strobe_q    <= kbd_strobe;
            overflow_q  <= push && full && !pop && !flush;
        end
    end
endmodule
